// File: rtl/overlay_scheduler.sv
// Chooses an overlay colour from per-frame NPU symbol scores with a persistence filter,
// and applies it to a grayscale pixel stream only at frame boundaries.
module overlay_scheduler #(
    parameter int THRESHOLD = 170,
    parameter int PERSIST   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               score_valid,
    input  logic [1:0]         score_idx,
    input  logic signed [31:0] score,
    input  logic               pixel_valid_in,
    input  logic [7:0]         data_in,
    output logic               pixel_valid_out,
    output logic [7:0]         r_out,
    output logic [7:0]         g_out,
    output logic [7:0]         b_out,
    output logic [2:0]         active_sel,
    output logic               frame_drop
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DECIDE  = 2'd2;

    localparam logic [2:0] SEL_NONE  = 3'd4;
    localparam logic [3:0] PERSIST_L = 4'(PERSIST);

    logic [1:0]         state;
    logic [3:0]         mask;
    logic signed [31:0] slots [4];
    logic [2:0]         candidate;
    logic [2:0]         pending;
    logic [3:0]         count;

    logic [2:0]         winner;
    logic signed [31:0] best_score;
    logic [3:0]         next_count;

    // Strict greater-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        winner     = SEL_NONE;
        best_score = '0;
        for (int i = 0; i < 4; i++) begin
            if (slots[i] > THRESHOLD && (winner == SEL_NONE || slots[i] > best_score)) begin
                winner     = 3'(i);
                best_score = slots[i];
            end
        end
    end

    always_comb begin
        next_count = 4'd1;
        if (winner == candidate) begin
            next_count = (count == 4'd15) ? 4'd15 : count + 4'd1;
        end
    end

    // A DECIDE cycle always commits its decision, even when a new frame starts in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mask       <= 4'd0;
            candidate  <= SEL_NONE;
            pending    <= SEL_NONE;
            count      <= 4'd0;
            active_sel <= SEL_NONE;
            frame_drop <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slots[i] <= '0;
            end
        end else begin
            frame_drop <= 1'b0;
            if (state == DECIDE) begin
                candidate <= winner;
                count     <= next_count;
                if (next_count >= PERSIST_L) begin
                    pending <= winner;
                end
            end
            if (frame_start) begin
                active_sel <= pending;
                if (state == COLLECT && mask != 4'hF) begin
                    frame_drop <= 1'b1;
                end
                state <= COLLECT;
                mask  <= score_valid ? (4'b0001 << score_idx) : 4'd0;
                if (score_valid) begin
                    slots[score_idx] <= score;
                end
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    COLLECT: begin
                        if (mask == 4'hF) begin
                            state <= DECIDE;
                        end
                        if (score_valid) begin
                            slots[score_idx] <= score;
                            mask             <= mask | (4'b0001 << score_idx);
                        end
                    end
                    DECIDE:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // With no overlay the pixel is lightened into the upper quarter of the grey range.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_valid_out <= 1'b0;
            r_out           <= 8'h00;
            g_out           <= 8'h00;
            b_out           <= 8'h00;
        end else begin
            pixel_valid_out <= pixel_valid_in;
            case (active_sel)
                3'd0: begin r_out <= 8'hFF; g_out <= 8'hFF; b_out <= 8'h00; end
                3'd1: begin r_out <= 8'h00; g_out <= 8'hFF; b_out <= 8'h00; end
                3'd2: begin r_out <= 8'h00; g_out <= 8'h00; b_out <= 8'hFF; end
                3'd3: begin r_out <= 8'hFF; g_out <= 8'h00; b_out <= 8'h00; end
                default: begin
                    r_out <= {2'b11, data_in[7:2]};
                    g_out <= {2'b11, data_in[7:2]};
                    b_out <= {2'b11, data_in[7:2]};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_overlay_scheduler.sv
// Directed bench for overlay_scheduler: frame decisions, persistence, drops, reset and pixel colouring.
module tb_overlay_scheduler;

    logic               clk = 1'b0;
    logic               reset;
    logic               frame_start;
    logic               score_valid;
    logic [1:0]         score_idx;
    logic signed [31:0] score;
    logic               pixel_valid_in;
    logic [7:0]         data_in;
    logic               pixel_valid_out;
    logic [7:0]         r_out;
    logic [7:0]         g_out;
    logic [7:0]         b_out;
    logic [2:0]         active_sel;
    logic               frame_drop;

    int tests  = 0;
    int errors = 0;

    overlay_scheduler #(.THRESHOLD(170), .PERSIST(3)) dut (
        .clk(clk),
        .reset(reset),
        .frame_start(frame_start),
        .score_valid(score_valid),
        .score_idx(score_idx),
        .score(score),
        .pixel_valid_in(pixel_valid_in),
        .data_in(data_in),
        .pixel_valid_out(pixel_valid_out),
        .r_out(r_out),
        .g_out(g_out),
        .b_out(b_out),
        .active_sel(active_sel),
        .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; frame_start = 1'b0; score_valid = 1'b0; score_idx = 2'd0;
        score = 32'sd0; pixel_valid_in = 1'b0; data_in = 8'h00;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_scores(input int s0, input int s1, input int s2, input int s3);
        int v [4];
        v = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            score_valid = 1'b1; score_idx = 2'(i); score = v[i];
            tick();
        end
        score_valid = 1'b0;
    endtask

    task automatic run_frame(input int s0, input int s1, input int s2, input int s3);
        pulse_frame();
        send_scores(s0, s1, s2, s3);
        tick();
        tick();
    endtask

    task automatic drive_pixel(input logic [7:0] px);
        pixel_valid_in = 1'b1; data_in = px;
        tick();
        pixel_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (active_sel !== 3'd4) begin errors++; $display("[TB] FAIL reset_active_sel got %0d exp 4", active_sel); end
        tests++; if ({r_out, g_out, b_out} !== 24'h0) begin errors++; $display("[TB] FAIL reset_rgb got %h exp 000000", {r_out, g_out, b_out}); end
        tests++; if (pixel_valid_out !== 1'b0 || frame_drop !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got pvo=%b drop=%b exp 0 0", pixel_valid_out, frame_drop); end
        tests++; if (dut.state !== 2'd0 || dut.count !== 4'd0) begin errors++; $display("[TB] FAIL reset_state got state=%0d count=%0d exp 0 0", dut.state, dut.count); end
    endtask

    task automatic test_persist_basic();
        do_reset();
        for (int f = 0; f < 3; f++) run_frame(100, 200, 50, 171);
        tests++; if (dut.pending !== 3'd1) begin errors++; $display("[TB] FAIL basic_pending got %0d exp 1", dut.pending); end
        tests++; if (active_sel !== 3'd4) begin errors++; $display("[TB] FAIL basic_sel_before got %0d exp 4", active_sel); end
        pulse_frame();
        tests++; if (active_sel !== 3'd1) begin errors++; $display("[TB] FAIL basic_sel_after got %0d exp 1", active_sel); end
        drive_pixel(8'h80);
        tests++; if ({r_out, g_out, b_out} !== 24'h00FF00 || pixel_valid_out !== 1'b1) begin errors++; $display("[TB] FAIL basic_pixel got %h pvo=%b exp 00ff00 1", {r_out, g_out, b_out}, pixel_valid_out); end
        tick();
        tests++; if (pixel_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_pvo_drop got %b exp 0", pixel_valid_out); end
    endtask

    task automatic test_threshold();
        do_reset();
        for (int f = 0; f < 3; f++) run_frame(170, 170, 170, 170);
        tests++; if (dut.candidate !== 3'd4 || dut.count !== 4'd3 || dut.pending !== 3'd4) begin errors++; $display("[TB] FAIL thr_decision got cand=%0d count=%0d pend=%0d exp 4 3 4", dut.candidate, dut.count, dut.pending); end
        pulse_frame();
        tests++; if (active_sel !== 3'd4) begin errors++; $display("[TB] FAIL thr_sel got %0d exp 4", active_sel); end
        drive_pixel(8'h80);
        tests++; if ({r_out, g_out, b_out} !== 24'hE0E0E0) begin errors++; $display("[TB] FAIL thr_pixel got %h exp e0e0e0", {r_out, g_out, b_out}); end
    endtask

    task automatic test_tie();
        do_reset();
        run_frame(180, 180, 10, 10);
        tests++; if (dut.candidate !== 3'd0 || dut.count !== 4'd1) begin errors++; $display("[TB] FAIL tie_low got cand=%0d count=%0d exp 0 1", dut.candidate, dut.count); end
        run_frame(-5, 300, 300, 0);
        tests++; if (dut.candidate !== 3'd1 || dut.count !== 4'd1) begin errors++; $display("[TB] FAIL tie_mid got cand=%0d count=%0d exp 1 1", dut.candidate, dut.count); end
        run_frame(-300, -200, 171, 171);
        tests++; if (dut.candidate !== 3'd2) begin errors++; $display("[TB] FAIL tie_neg got cand=%0d exp 2", dut.candidate); end
    endtask

    task automatic test_drop();
        do_reset();
        run_frame(0, 0, 200, 0);
        run_frame(0, 0, 200, 0);
        pulse_frame();
        for (int i = 0; i < 3; i++) begin
            score_valid = 1'b1; score_idx = 2'(i); score = (i == 2) ? 200 : 0;
            tick();
        end
        score_valid = 1'b0;
        pulse_frame();
        tests++; if (frame_drop !== 1'b1) begin errors++; $display("[TB] FAIL drop_pulse got %b exp 1", frame_drop); end
        tests++; if (dut.count !== 4'd2 || dut.candidate !== 3'd2 || active_sel !== 3'd4) begin errors++; $display("[TB] FAIL drop_hold got count=%0d cand=%0d sel=%0d exp 2 2 4", dut.count, dut.candidate, active_sel); end
        tick();
        tests++; if (frame_drop !== 1'b0) begin errors++; $display("[TB] FAIL drop_single got %b exp 0", frame_drop); end
        send_scores(0, 0, 200, 0);
        tick();
        tick();
        tests++; if (dut.count !== 4'd3 || dut.pending !== 3'd2) begin errors++; $display("[TB] FAIL drop_resume got count=%0d pend=%0d exp 3 2", dut.count, dut.pending); end
        pulse_frame();
        tests++; if (active_sel !== 3'd2 || frame_drop !== 1'b0) begin errors++; $display("[TB] FAIL drop_apply got sel=%0d drop=%b exp 2 0", active_sel, frame_drop); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int f = 0; f < 3; f++) run_frame(0, 0, 0, 250);
        pulse_frame();
        tests++; if (active_sel !== 3'd3) begin errors++; $display("[TB] FAIL rmid_sel got %0d exp 3", active_sel); end
        drive_pixel(8'h55);
        tests++; if ({r_out, g_out, b_out} !== 24'hFF0000) begin errors++; $display("[TB] FAIL rmid_pixel got %h exp ff0000", {r_out, g_out, b_out}); end
        score_valid = 1'b1; score_idx = 2'd0; score = 250;
        tick();
        reset = 1'b1; score_idx = 2'd1; pixel_valid_in = 1'b1; data_in = 8'hFF;
        tick();
        reset = 1'b0; score_valid = 1'b0; pixel_valid_in = 1'b0;
        tests++; if (active_sel !== 3'd4 || {r_out, g_out, b_out} !== 24'h0 || pixel_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL rmid_outputs got sel=%0d rgb=%h pvo=%b exp 4 000000 0", active_sel, {r_out, g_out, b_out}, pixel_valid_out); end
        tests++; if (dut.state !== 2'd0 || dut.mask !== 4'd0) begin errors++; $display("[TB] FAIL rmid_state got state=%0d mask=%b exp 0 0000", dut.state, dut.mask); end
        send_scores(0, 0, 0, 250);
        tick();
        tick();
        tests++; if (dut.state !== 2'd0 || dut.mask !== 4'd0 || dut.count !== 4'd0 || dut.candidate !== 3'd4) begin errors++; $display("[TB] FAIL rmid_ignore got state=%0d mask=%b count=%0d cand=%0d exp 0 0000 0 4", dut.state, dut.mask, dut.count, dut.candidate); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_frame(0, 200, 0, 0);
        run_frame(0, 200, 0, 0);
        pulse_frame();
        send_scores(0, 200, 0, 0);
        tick();
        tests++; if (dut.state !== 2'd2) begin errors++; $display("[TB] FAIL b2b_decide got state=%0d exp 2", dut.state); end
        frame_start = 1'b1; score_valid = 1'b1; score_idx = 2'd0; score = 5;
        tick();
        frame_start = 1'b0; score_valid = 1'b0;
        tests++; if (active_sel !== 3'd4 || dut.pending !== 3'd1 || dut.count !== 4'd3) begin errors++; $display("[TB] FAIL b2b_commit got sel=%0d pend=%0d count=%0d exp 4 1 3", active_sel, dut.pending, dut.count); end
        tests++; if (dut.state !== 2'd1 || dut.mask !== 4'b0001 || frame_drop !== 1'b0) begin errors++; $display("[TB] FAIL b2b_newframe got state=%0d mask=%b drop=%b exp 1 0001 0", dut.state, dut.mask, frame_drop); end
        send_scores(0, 200, 0, 0);
        tick();
        tick();
        pulse_frame();
        tests++; if (active_sel !== 3'd1) begin errors++; $display("[TB] FAIL b2b_apply got %0d exp 1", active_sel); end
    endtask

    task automatic test_sequence();
        logic [2:0] win  [6] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd1};
        logic [2:0] pend [6] = '{3'd4, 3'd4, 3'd1, 3'd1, 3'd1, 3'd1};
        logic [3:0] cnt  [6] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd1};
        do_reset();
        for (int f = 0; f < 6; f++) begin
            if (win[f] == 3'd1) run_frame(0, 200, 0, 0);
            else                run_frame(0, 0, 200, 0);
            tests++; if (dut.pending !== pend[f] || dut.count !== cnt[f]) begin errors++; $display("[TB] FAIL seq_frame%0d got pend=%0d count=%0d exp %0d %0d", f + 1, dut.pending, dut.count, pend[f], cnt[f]); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int f = 0; f < 17; f++) run_frame(200, 0, 0, 0);
        tests++; if (dut.count !== 4'd15 || dut.pending !== 3'd0) begin errors++; $display("[TB] FAIL sat_count got count=%0d pend=%0d exp 15 0", dut.count, dut.pending); end
    endtask

    initial begin
        test_reset();
        test_persist_basic();
        test_threshold();
        test_tie();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        test_sequence();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
